// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset controller: state encoding,
// instruction field constants, ula32 operation codes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_BOOT,
    S_FETCH,
    S_FETCH_LD,
    S_DECODE,
    S_ALU_R,
    S_ALU_I,
    S_ALU_WB,
    S_EXC,
    S_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_MDR_LD,
    S_LW_WB,
    S_BRANCH,
    S_JUMP
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ULA_ADD = 3'b001;
  localparam logic [2:0] ULA_SUB = 3'b010;
  localparam logic [2:0] ULA_AND = 3'b011;

  localparam logic       SRCA_PC = 1'b0;
  localparam logic       SRCA_A  = 1'b1;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_4      = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic       IORD_PC     = 1'b0;
  localparam logic       IORD_ALUOUT = 1'b1;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_SP = 2'd2;

  localparam logic [1:0] MEMTOREG_ALUOUT   = 2'd0;
  localparam logic [1:0] MEMTOREG_MDR      = 2'd1;
  localparam logic [1:0] MEMTOREG_RESET_SP = 2'd2;

  localparam logic [1:0] PCSRC_ULA    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_EXC    = 2'd3;

  localparam logic       EXC_BAD_OP = 1'b0;
  localparam logic       EXC_OVF    = 1'b1;

  typedef struct packed {
    logic       pc_write;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       rb_write;
    logic       ab_write;
    logic       aluout_write;
    logic       epc_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] ula_control;
    logic       iord;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_source;
    logic       exc_sel;
  } ctrl_t;

  function automatic logic r_funct_known(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND);
  endfunction

  function automatic logic [2:0] r_ula(input logic [5:0] funct);
    logic [2:0] code;
    case (funct)
      FN_SUB:  code = ULA_SUB;
      FN_AND:  code = ULA_AND;
      default: code = ULA_ADD;
    endcase
    return code;
  endfunction

  // Only signed add/sub/addi trap on overflow; 'and' never does.
  function automatic logic can_overflow(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OP_ADDI) ||
           ((opcode == OP_R) && ((funct == FN_ADD) || (funct == FN_SUB)));
  endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// 3-bit down counter timing the memory wait cycles of fetch and load reads.
// Loaded while idle, counts down while enabled, and reports done at zero.
module mem_wait_ctr (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       dec_i,
  input  logic [2:0] load_val_i,
  output logic       done_o
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 3'd0);

endmodule

// File: rtl/ctrl_fsm_mc.sv
// Multicycle control FSM for the MIPS-subset datapath: Moore decode of state
// into every datapath enable/select, with branch and writeback flag qualifiers.
module ctrl_fsm_mc
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int SP_REG   = 29,
  parameter int RESET_SP = 227
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       OVERFLOW,
  input  logic       EQUAL,
  output logic       PC_Write,
  output logic       MEM_Write,
  output logic       IR_Write,
  output logic       MDR_Write,
  output logic       RB_Write,
  output logic       AB_Write,
  output logic       ALUOut_Write,
  output logic       EPC_Write,
  output logic       ALUsrc_A,
  output logic [1:0] ALUsrc_B,
  output logic [2:0] ULA_Control,
  output logic       IorD,
  output logic [1:0] RegDst,
  output logic [1:0] MemToReg,
  output logic [1:0] PCSource,
  output logic       ExcSel,
  output logic [3:0] dbg_state_o
);

  // Out-of-range parameters fall back to the longest supported memory wait.
  localparam bit PARAMS_OK = (MEM_WAIT >= 0) && (MEM_WAIT <= 7) &&
                             (SP_REG >= 0) && (SP_REG <= 31) && (RESET_SP >= 0);
  localparam logic [2:0] WAIT_LOAD = PARAMS_OK ? 3'(MEM_WAIT) : 3'd7;

  state_t state_q;
  state_t state_d;
  logic   exc_sel_q;
  logic   exc_sel_d;
  ctrl_t  ctrl;

  logic   wait_load;
  logic   wait_done;
  logic   ovf_exc;
  logic   wb_imm;

  assign wait_load = (state_q != S_FETCH) && (state_q != S_MEM_RD);
  assign ovf_exc   = OVERFLOW && can_overflow(OPCODE, FUNCT);
  assign wb_imm    = (OPCODE == OP_ADDI);

  mem_wait_ctr u_wait (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (wait_load),
    .dec_i      (!wait_load),
    .load_val_i (WAIT_LOAD),
    .done_o     (wait_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_BOOT;
      exc_sel_q <= EXC_BAD_OP;
    end else begin
      state_q   <= state_d;
      exc_sel_q <= exc_sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    exc_sel_d = exc_sel_q;
    case (state_q)
      S_BOOT:     state_d = S_FETCH;
      S_FETCH:    if (wait_done) state_d = S_FETCH_LD;
      S_FETCH_LD: state_d = S_DECODE;
      S_DECODE: begin
        case (OPCODE)
          OP_R: begin
            if (r_funct_known(FUNCT)) begin
              state_d = S_ALU_R;
            end else begin
              state_d   = S_EXC;
              exc_sel_d = EXC_BAD_OP;
            end
          end
          OP_ADDI:        state_d = S_ALU_I;
          OP_LW, OP_SW:   state_d = S_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          default: begin
            state_d   = S_EXC;
            exc_sel_d = EXC_BAD_OP;
          end
        endcase
      end
      S_ALU_R, S_ALU_I: state_d = S_ALU_WB;
      S_ALU_WB: begin
        if (ovf_exc) begin
          state_d   = S_EXC;
          exc_sel_d = EXC_OVF;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_EXC:    state_d = S_FETCH;
      S_ADDR:   state_d = (OPCODE == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_WR: state_d = S_FETCH;
      S_MEM_RD: if (wait_done) state_d = S_MDR_LD;
      S_MDR_LD: state_d = S_LW_WB;
      S_LW_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_BOOT;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_BOOT: begin
        ctrl.rb_write   = 1'b1;
        ctrl.reg_dst    = REGDST_SP;
        ctrl.mem_to_reg = MEMTOREG_RESET_SP;
      end
      S_FETCH: ctrl.iord = IORD_PC;
      S_FETCH_LD: begin
        ctrl.ir_write    = 1'b1;
        ctrl.pc_write    = 1'b1;
        ctrl.alu_src_a   = SRCA_PC;
        ctrl.alu_src_b   = SRCB_4;
        ctrl.ula_control = ULA_ADD;
        ctrl.pc_source   = PCSRC_ULA;
      end
      S_DECODE: begin
        ctrl.ab_write     = 1'b1;
        ctrl.aluout_write = 1'b1;
        ctrl.alu_src_a    = SRCA_PC;
        ctrl.alu_src_b    = SRCB_IMM_SH;
        ctrl.ula_control  = ULA_ADD;
      end
      S_ALU_R: begin
        ctrl.alu_src_a    = SRCA_A;
        ctrl.alu_src_b    = SRCB_B;
        ctrl.ula_control  = r_ula(FUNCT);
        ctrl.aluout_write = 1'b1;
      end
      S_ALU_I: begin
        ctrl.alu_src_a    = SRCA_A;
        ctrl.alu_src_b    = SRCB_IMM;
        ctrl.ula_control  = ULA_ADD;
        ctrl.aluout_write = 1'b1;
      end
      S_ALU_WB: begin
        // Operands stay selected so the overflow flag still refers to this op.
        ctrl.alu_src_a   = SRCA_A;
        ctrl.alu_src_b   = wb_imm ? SRCB_IMM : SRCB_B;
        ctrl.ula_control = wb_imm ? ULA_ADD : r_ula(FUNCT);
        if (ovf_exc) begin
          ctrl.epc_write = 1'b1;
        end else begin
          ctrl.rb_write   = 1'b1;
          ctrl.reg_dst    = wb_imm ? REGDST_RT : REGDST_RD;
          ctrl.mem_to_reg = MEMTOREG_ALUOUT;
        end
      end
      S_EXC: begin
        ctrl.epc_write   = 1'b1;
        ctrl.pc_write    = 1'b1;
        ctrl.alu_src_a   = SRCA_PC;
        ctrl.alu_src_b   = SRCB_4;
        ctrl.ula_control = ULA_SUB;
        ctrl.pc_source   = PCSRC_EXC;
        ctrl.exc_sel     = exc_sel_q;
      end
      S_ADDR: begin
        ctrl.alu_src_a    = SRCA_A;
        ctrl.alu_src_b    = SRCB_IMM;
        ctrl.ula_control  = ULA_ADD;
        ctrl.aluout_write = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.iord      = IORD_ALUOUT;
        ctrl.mem_write = 1'b1;
      end
      S_MEM_RD: ctrl.iord = IORD_ALUOUT;
      S_MDR_LD: ctrl.mdr_write = 1'b1;
      S_LW_WB: begin
        ctrl.rb_write   = 1'b1;
        ctrl.reg_dst    = REGDST_RT;
        ctrl.mem_to_reg = MEMTOREG_MDR;
      end
      S_BRANCH: begin
        ctrl.alu_src_a   = SRCA_A;
        ctrl.alu_src_b   = SRCB_B;
        ctrl.ula_control = ULA_SUB;
        ctrl.pc_source   = PCSRC_ALUOUT;
        ctrl.pc_write    = (OPCODE == OP_BNE) ? ~EQUAL : EQUAL;
      end
      S_JUMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      default: ctrl = '0;
    endcase
    // Gating on reset makes a pending memory write drop without waiting for a clock.
    if (reset) ctrl = '0;
  end

  assign PC_Write     = ctrl.pc_write;
  assign MEM_Write    = ctrl.mem_write;
  assign IR_Write     = ctrl.ir_write;
  assign MDR_Write    = ctrl.mdr_write;
  assign RB_Write     = ctrl.rb_write;
  assign AB_Write     = ctrl.ab_write;
  assign ALUOut_Write = ctrl.aluout_write;
  assign EPC_Write    = ctrl.epc_write;
  assign ALUsrc_A     = ctrl.alu_src_a;
  assign ALUsrc_B     = ctrl.alu_src_b;
  assign ULA_Control  = ctrl.ula_control;
  assign IorD         = ctrl.iord;
  assign RegDst       = ctrl.reg_dst;
  assign MemToReg     = ctrl.mem_to_reg;
  assign PCSource     = ctrl.pc_source;
  assign ExcSel       = ctrl.exc_sel;
  assign dbg_state_o  = state_q;

endmodule
